// File: rtl/fsm_pkg.sv
// Shared FSM encodings for the serial feeder/detector family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: state encodings (IDLE/SHIFT/GAP) and the gap counter width.
package fsm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_t;

endpackage

// File: rtl/parallel_to_serial.sv
// Parallel word -> serial bit stream feeder for the serial sequence detectors.
// Latency: word accepted at edge N -> first bit on ser_out in cycle N+1; DATA_W bits, no bubbles.
// Backpressure: din_ready low while shifting (except the last bit when GAP_CYCLES==0) and in GAP.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din/din_valid     parallel word in, held by upstream until accepted
//   din_ready         word accepted on din_valid & din_ready
//   ser_out/ser_valid registered serial bit and its qualifier (ser_out=0 when not valid)
//   frame_done        pulse with the last bit of each frame
//   busy              high in SHIFT or GAP
module parallel_to_serial
  import fsm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit BACK_TO_BACK = (GAP_CYCLES == 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_cnt_nxt;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_frame_done;

  logic              w_last;
  logic              w_accept;
  logic              w_head_nxt;
  logic [DATA_W-1:0] w_shifted;

  assign w_last    = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);
  // Without a gap the next word may be taken while its predecessor's last bit is on the wire.
  assign din_ready = (r_state == S_IDLE) || (w_last && BACK_TO_BACK);
  assign w_accept  = din_valid && din_ready;
  assign busy      = (r_state != S_IDLE);

  // The head of shreg is the bit on the wire; shifting moves the next bit into the head slot.
  assign w_shifted  = MSB_FIRST ? {r_shreg[DATA_W-2:0], 1'b0} : {1'b0, r_shreg[DATA_W-1:1]};
  assign w_head_nxt = MSB_FIRST ? w_shreg_nxt[DATA_W-1] : w_shreg_nxt[0];

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt   = din;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (w_accept) begin
            w_shreg_nxt   = din;
            w_bit_cnt_nxt = '0;
          end else if (GAP_CYCLES > 0) begin
            w_gap_cnt_nxt = GAP_LOAD;
            w_state_nxt   = S_GAP;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_shreg_nxt   = w_shifted;
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        // gap_cnt is loaded with GAP_CYCLES-1, so the GAP state lasts exactly GAP_CYCLES cycles.
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_ser_out    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      // Outputs are registered from next-state so they line up with the SHIFT cycle they describe.
      r_ser_valid  <= (w_state_nxt == S_SHIFT);
      r_ser_out    <= (w_state_nxt == S_SHIFT) && w_head_nxt;
      r_frame_done <= (w_state_nxt == S_SHIFT) && (w_bit_cnt_nxt == LAST_BIT);
    end
  end

  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: three instances cover MSB-first/no gap,
// LSB-first/no gap and MSB-first/2-cycle gap. Expected serial patterns are hand-written
// in transmission order (leftmost bit goes out first).
module tb_parallel_to_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0][7:0] din;
  logic [2:0]      dv;
  logic [2:0]      rdy;
  logic [2:0]      so;
  logic [2:0]      sv;
  logic [2:0]      fd;
  logic [2:0]      bz;

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_done(fd[0]), .busy(bz[0])
  );

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .frame_done(fd[1]), .busy(bz[1])
  );

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .frame_done(fd[2]), .busy(bz[2])
  );

  int       n_chk = 0;
  int       n_bad = 0;
  logic [2:0] hist;
  int       det;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Checks one bit cycle of a frame on instance d; k is the 1-based bit index.
  task automatic chk_bit(input int d, input int k, input logic [7:0] pat, input bit exp_fd);
    chk($sformatf("d%0d bit%0d ser_valid", d, k), 8'(sv[d]), 8'd1);
    chk($sformatf("d%0d bit%0d ser_out", d, k), 8'(so[d]), 8'(pat[8-k]));
    chk($sformatf("d%0d bit%0d frame_done", d, k), 8'(fd[d]), 8'(exp_fd));
    chk($sformatf("d%0d bit%0d busy", d, k), 8'(bz[d]), 8'd1);
    if (sv[d]) begin
      hist = {hist[1:0], so[d]};
      if (hist == 3'b101) det++;
    end
  endtask

  // Called in the first bit cycle; returns in the cycle after the last bit.
  task automatic chk_frame(input int d, input logic [7:0] pat);
    for (int k = 1; k <= 8; k++) begin
      chk_bit(d, k, pat, (k == 8));
      tick();
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, " ser_valid"}, 8'(sv[d]), 8'd0);
    chk({tag, " ser_out"}, 8'(so[d]), 8'd0);
    chk({tag, " frame_done"}, 8'(fd[d]), 8'd0);
    chk({tag, " busy"}, 8'(bz[d]), 8'd0);
    chk({tag, " din_ready"}, 8'(rdy[d]), 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stray;
    rst  = 1'b1;
    din  = '0;
    dv   = '0;
    hist = '0;
    det  = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) chk_idle(d, $sformatf("reset d%0d", d));

    // 1: MSB first, 0000_0101 -> 0,0,0,0,0,1,0,1; detector sees one 101.
    din[0] = 8'b0000_0101;
    dv[0]  = 1'b1;
    tick();
    dv[0] = 1'b0;
    hist  = '0;
    det   = 0;
    chk_frame(0, 8'b0000_0101);
    chk_idle(0, "t1 after");
    chk("t1 detector hits", 8'(det), 8'd1);

    // 2: LSB first, A0 -> 0,0,0,0,0,1,0,1.
    din[1] = 8'hA0;
    dv[1]  = 1'b1;
    tick();
    dv[1] = 1'b0;
    chk_frame(1, 8'b0000_0101);
    chk_idle(1, "t2 after");

    // 3: back-to-back FF then 00 with din_valid held.
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    tick();
    din[0] = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) dv[0] = 1'b0;
      chk($sformatf("t3 c%0d ser_valid", k), 8'(sv[0]), 8'd1);
      chk($sformatf("t3 c%0d ser_out", k), 8'(so[0]), (k <= 8) ? 8'd1 : 8'd0);
      chk($sformatf("t3 c%0d frame_done", k), 8'(fd[0]), (k == 8 || k == 16) ? 8'd1 : 8'd0);
      if (k == 8) chk("t3 last-bit din_ready", 8'(rdy[0]), 8'd1);
      if (k == 2) chk("t3 mid-frame din_ready", 8'(rdy[0]), 8'd0);
      tick();
    end
    chk_idle(0, "t3 after");

    // 4: GAP_CYCLES=2, C3 then 5A waiting on din.
    din[2] = 8'hC3;
    dv[2]  = 1'b1;
    tick();
    din[2] = 8'h5A;
    chk_frame(2, 8'hC3);
    for (int c = 9; c <= 10; c++) begin
      chk($sformatf("t4 c%0d ser_valid", c), 8'(sv[2]), 8'd0);
      chk($sformatf("t4 c%0d ser_out", c), 8'(so[2]), 8'd0);
      chk($sformatf("t4 c%0d din_ready", c), 8'(rdy[2]), 8'd0);
      chk($sformatf("t4 c%0d busy", c), 8'(bz[2]), 8'd1);
      tick();
    end
    chk_idle(2, "t4 c11");
    tick();
    dv[2] = 1'b0;
    chk_frame(2, 8'h5A);
    chk("t4 c20 ser_valid", 8'(sv[2]), 8'd0);
    chk("t4 c20 busy", 8'(bz[2]), 8'd1);
    tick();
    tick();
    chk_idle(2, "t4 settled");

    // 5: reset during the third bit abandons the frame.
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    tick();
    dv[0] = 1'b0;
    tick();
    tick();
    chk("t5 bit3 ser_valid", 8'(sv[0]), 8'd1);
    chk("t5 bit3 ser_out", 8'(so[0]), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle(0, "t5 post-rst");
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sv[0] || so[0] || fd[0]) stray++;
    end
    chk("t5 residual bits", 8'(stray), 8'd0);

    // 6: din toggled mid-frame is ignored; 81 waiting at the last bit is taken back-to-back.
    din[1] = 8'hA0;
    dv[1]  = 1'b1;
    tick();
    dv[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        din[1] = 8'hFF;
        dv[1]  = 1'b1;
      end
      if (k == 4) dv[1] = 1'b0;
      if (k == 5) begin
        din[1] = 8'h81;
        dv[1]  = 1'b1;
      end
      if (k == 3) chk("t6 din_ready while shifting", 8'(rdy[1]), 8'd0);
      chk_bit(1, k, 8'b0000_0101, (k == 8));
      tick();
    end
    dv[1] = 1'b0;
    chk_frame(1, 8'b1000_0001);
    chk_idle(1, "t6 after");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
